// File: rtl/grf.sv
// grf: 32x32 MIPS register file, $0 hardwired to zero, write bypass on both read ports
module grf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter bit LOG_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              wr_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (we && a3 != '0) begin
            regs[a3] <= wd;
        end
    end

    // Bypass is suppressed during reset so readers see the stored contents.
    assign wr_live = we && !reset;

    always_comb begin
        rd1 = (a1 == '0) ? '0 : (wr_live && a3 == a1) ? wd : regs[a1];
        rd2 = (a2 == '0) ? '0 : (wr_live && a3 == a2) ? wd : regs[a2];
    end

    if (LOG_EN) begin : g_log
        always @(posedge clk) begin
            if (wr_live) $display("@%h: $%d <= %h", pc, a3, wd);
        end
    end
endmodule

// File: tb/tb_grf.sv
// tb_grf: directed scoreboard bench for grf covering reset, write/read, $0, bypass and reset priority
module tb_grf;
    logic        clk = 0;
    logic        reset;
    logic        we;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd, pc;
    logic [31:0] rd1, rd2;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    grf dut (
        .clk(clk), .reset(reset), .we(we), .a1(a1), .a2(a2), .a3(a3),
        .wd(wd), .pc(pc), .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: got %h but scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        we = 1; a3 = a; wd = d; pc = p;
        @(negedge clk);
        we = 0;
    endtask

    initial begin
        reset = 1; we = 0; a1 = 0; a2 = 0; a3 = 0; wd = 0; pc = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            push(0); push(0);
            #1;
            cmp("reset_rd1", rd1);
            cmp("reset_rd2", rd2);
        end

        wr(5, 32'h12345678, 32'h00003000);
        a1 = 5; push(32'h12345678); #1; cmp("readback5", rd1);

        we = 1; a3 = 0; wd = 32'hFFFFFFFF; pc = 32'h00003004; a1 = 0;
        push(0); #1; cmp("zero_during", rd1);
        @(negedge clk);
        we = 0;
        push(0); #1; cmp("zero_after", rd1);

        wr(8, 32'h11, 32'h00003008);
        we = 1; a3 = 8; wd = 32'hAA; pc = 32'h0000300c; a1 = 8; a2 = 8;
        push(32'hAA); push(32'hAA); #1;
        cmp("bypass_rd1", rd1);
        cmp("bypass_rd2", rd2);
        we = 0;
        push(32'h11); push(32'h11); #1;
        cmp("nobypass_rd1", rd1);
        cmp("nobypass_rd2", rd2);

        wr(3, 32'h33, 32'h00003010);
        a1 = 3; a2 = 5;
        push(32'h33); push(32'h12345678); #1;
        cmp("pre_reset_rd1", rd1);
        cmp("pre_reset_rd2", rd2);
        reset = 1; we = 1; a3 = 3; wd = 7; pc = 32'h00003014;
        push(32'h33); #1; cmp("reset_no_bypass", rd1);
        @(negedge clk);
        push(0); #1; cmp("reset_beats_write", rd1);
        reset = 0; we = 0; a1 = 5; a2 = 8;
        push(0); push(0); #1;
        cmp("lost_rd1", rd1);
        cmp("lost_rd2", rd2);

        wr(31, 32'hDEADBEEF, 32'h00003018);
        a2 = 31; push(32'hDEADBEEF); #1; cmp("b2b_first", rd2);
        wr(31, 32'hCAFEF00D, 32'h0000301c);
        push(32'hCAFEF00D); #1; cmp("b2b_second", rd2);
        a1 = 31; a2 = 8; push(32'hCAFEF00D); push(0); #1;
        cmp("indep_rd1", rd1);
        cmp("indep_rd2", rd2);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
